// File: rtl/wavuno_pkg.sv
// Shared types and constants for the WAV add-on sample player.
// Build option: WAVUNO_UNDERRUN_MUTE_EN selects mute-on-underrun in wavuno_sample_player.
package wavuno_pkg;

  localparam int SAMPLE_W        = 8;
  localparam int DEFAULT_FIFO_AW = 4;

  typedef logic [SAMPLE_W-1:0] sample_t;

  localparam sample_t MIDSCALE = 8'h80;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PLAY = 1'b1
  } play_state_t;

endpackage

// File: rtl/wavuno_sd_dac.sv
// One-channel first-order sigma-delta modulator: bitstream duty equals sample/256.
module wavuno_sd_dac
  import wavuno_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  sample_t sample,
  output logic    bitstream
);

  logic [SAMPLE_W:0] acc;

  // The carry out of the 8-bit phase accumulator is the output bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      bitstream <= 1'b0;
    end else begin
      acc       <= {1'b0, acc[SAMPLE_W-1:0]} + {1'b0, sample};
      bitstream <= acc[SAMPLE_W];
    end
  end

endmodule

// File: rtl/wavuno_sample_player.sv
// Stereo PCM playback: CPU-fed pair FIFO, sample-rate divider and two sigma-delta outputs.
// Build option: WAVUNO_UNDERRUN_MUTE_EN loads midscale on an underrun tick instead of holding.
module wavuno_sample_player
  import wavuno_pkg::*;
#(
  parameter int FIFO_AW = DEFAULT_FIFO_AW,
  parameter int DIV_W   = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [DIV_W-1:0]   rate_div,
  input  logic               wr_left,
  input  logic               wr_right,
  input  logic [7:0]         wr_data,
  input  logic               clr_flags,
  output logic [FIFO_AW:0]   fifo_count,
  output logic               fifo_full,
  output logic               fifo_empty,
  output logic               underrun,
  output logic               overflow,
  output logic               audio_out_left,
  output logic               audio_out_right
);

  localparam int              DEPTH     = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_CNT = (FIFO_AW + 1)'(DEPTH);

`ifdef WAVUNO_UNDERRUN_MUTE_EN
  localparam logic MUTE_ON = 1'b1;
`else
  localparam logic MUTE_ON = 1'b0;
`endif

  play_state_t        state;
  logic [DIV_W-1:0]   div_cnt;
  logic               tick;
  logic               pop;
  logic               push;
  logic               underrun_tick;

  sample_t            pend_left;
  sample_t            cur_left;
  sample_t            cur_right;
  sample_t            mem_left  [DEPTH];
  sample_t            mem_right [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;

  // Tick is gated by the live enable so a deasserting cycle never pops.
  assign tick          = (state == ST_PLAY) && enable && (div_cnt == '0);
  assign fifo_full     = (fifo_count == DEPTH_CNT);
  assign fifo_empty    = (fifo_count == '0);
  assign pop           = tick && !fifo_empty;
  assign underrun_tick = tick && fifo_empty;
  // Writes have no backpressure: a push into a full FIFO is dropped unless a pop frees a slot.
  assign push          = wr_right && (!fifo_full || pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      div_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          div_cnt <= rate_div;
          if (enable) state <= ST_PLAY;
        end
        ST_PLAY: begin
          if (!enable) begin
            state   <= ST_IDLE;
            div_cnt <= rate_div;
          end else if (div_cnt == '0) begin
            div_cnt <= rate_div;
          end else begin
            div_cnt <= div_cnt - 1'b1;
          end
        end
        default: begin
          state   <= ST_IDLE;
          div_cnt <= rate_div;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_left[wr_ptr]  <= pend_left;
      mem_right[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // The pushed pair takes the old pending left when both strobes coincide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_left <= MIDSCALE;
      cur_left  <= MIDSCALE;
      cur_right <= MIDSCALE;
    end else begin
      if (wr_left) pend_left <= wr_data;
      if (pop) begin
        cur_left  <= mem_left[rd_ptr];
        cur_right <= mem_right[rd_ptr];
      end else if (underrun_tick && MUTE_ON) begin
        cur_left  <= MIDSCALE;
        cur_right <= MIDSCALE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      underrun <= 1'b0;
      overflow <= 1'b0;
    end else begin
      underrun <= underrun_tick || (underrun && !clr_flags);
      overflow <= (wr_right && fifo_full && !pop) || (overflow && !clr_flags);
    end
  end

  wavuno_sd_dac u_dac_left (
    .clk       (clk),
    .rst       (rst),
    .sample    (cur_left),
    .bitstream (audio_out_left)
  );

  wavuno_sd_dac u_dac_right (
    .clk       (clk),
    .rst       (rst),
    .sample    (cur_right),
    .bitstream (audio_out_right)
  );

endmodule

// File: tb/tb_wavuno_sample_player.sv
// Directed bench for wavuno_sample_player; expected values are hand-computed constants.
module tb_wavuno_sample_player;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [11:0] rate_div;
  logic        wr_left;
  logic        wr_right;
  logic [7:0]  wr_data;
  logic        clr_flags;
  logic [4:0]  fifo_count;
  logic        fifo_full;
  logic        fifo_empty;
  logic        underrun;
  logic        overflow;
  logic        audio_out_left;
  logic        audio_out_right;

  int n_cmp  = 0;
  int n_fail = 0;
  int ones_l;
  int ones_r;

  always #5 clk = ~clk;

  wavuno_sample_player #(.FIFO_AW(4), .DIV_W(12)) dut (
    .clk             (clk),
    .rst             (rst),
    .enable          (enable),
    .rate_div        (rate_div),
    .wr_left         (wr_left),
    .wr_right        (wr_right),
    .wr_data         (wr_data),
    .clr_flags       (clr_flags),
    .fifo_count      (fifo_count),
    .fifo_full       (fifo_full),
    .fifo_empty      (fifo_empty),
    .underrun        (underrun),
    .overflow        (overflow),
    .audio_out_left  (audio_out_left),
    .audio_out_right (audio_out_right)
  );

  task automatic check(input string tag, input int observed, input int expected);
    n_cmp++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] l, input logic [7:0] r);
    wr_left = 1'b1;
    wr_data = l;
    step();
    wr_left  = 1'b0;
    wr_right = 1'b1;
    wr_data  = r;
    step();
    wr_right = 1'b0;
  endtask

  // With rate_div = 9 the single tick lands on the 11th edge after enable rises.
  task automatic pop_one();
    enable = 1'b1;
    repeat (11) @(posedge clk);
    #1;
    enable = 1'b0;
  endtask

  task automatic measure(output int ol, output int orr);
    ol  = 0;
    orr = 0;
    repeat (3) step();
    for (int k = 0; k < 256; k++) begin
      step();
      ol  += int'(audio_out_left);
      orr += int'(audio_out_right);
    end
  endtask

  task automatic expect_duty(input string tag, input int exp_l, input int exp_r);
    int ol;
    int orr;
    measure(ol, orr);
    check({tag, "_duty_l"}, ol, exp_l);
    check({tag, "_duty_r"}, orr, exp_r);
  endtask

  initial begin
    rst       = 1'b1;
    enable    = 1'b0;
    rate_div  = 12'd9;
    wr_left   = 1'b0;
    wr_right  = 1'b0;
    wr_data   = 8'h00;
    clr_flags = 1'b0;

    // Reset defaults
    #12;
    check("rst_count", int'(fifo_count), 0);
    check("rst_empty", int'(fifo_empty), 1);
    check("rst_full", int'(fifo_full), 0);
    check("rst_underrun", int'(underrun), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_out_l", int'(audio_out_left), 0);
    check("rst_out_r", int'(audio_out_right), 0);
    step();
    rst = 1'b0;
    repeat (100) step();
    check("idle_empty", int'(fifo_empty), 1);
    check("idle_count", int'(fifo_count), 0);
    expect_duty("idle", 128, 128);

    // Prefill and play
    push(8'h10, 8'hF0);
    push(8'h20, 8'hE0);
    check("prefill_count", int'(fifo_count), 2);
    enable = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("before_tick_count", int'(fifo_count), 2);
    step();
    check("first_tick_count", int'(fifo_count), 1);
    enable = 1'b0;
    expect_duty("pair1", 16, 240);
    pop_one();
    check("second_tick_count", int'(fifo_count), 0);
    check("second_tick_empty", int'(fifo_empty), 1);
    expect_duty("pair2", 32, 224);
    check("play_no_underrun", int'(underrun), 0);

    // Overflow
    for (int i = 0; i < 16; i++) push(8'(i), 8'(8'h80 + i));
    check("fill_count", int'(fifo_count), 16);
    check("fill_full", int'(fifo_full), 1);
    check("fill_no_overflow", int'(overflow), 0);
    push(8'h10, 8'h90);
    check("ovf_count", int'(fifo_count), 16);
    check("ovf_flag", int'(overflow), 1);
    clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
    check("ovf_cleared", int'(overflow), 0);

    // Push on the tick cycle while full
    enable = 1'b1;
    repeat (9) @(posedge clk);
    #1;
    wr_left = 1'b1;
    wr_data = 8'hAA;
    step();
    wr_left  = 1'b0;
    wr_right = 1'b1;
    wr_data  = 8'hBB;
    step();
    wr_right = 1'b0;
    enable   = 1'b0;
    check("fullpop_count", int'(fifo_count), 16);
    check("fullpop_full", int'(fifo_full), 1);
    check("fullpop_no_overflow", int'(overflow), 0);

    // Drain and check the popped order; the dropped 17th pair must not appear
    expect_duty("drain0", 0, 128);
    for (int i = 1; i < 16; i++) begin
      pop_one();
      expect_duty($sformatf("drain%0d", i), i, 128 + i);
    end
    pop_one();
    expect_duty("drain_last", 170, 187);
    check("drained_count", int'(fifo_count), 0);
    check("drained_underrun", int'(underrun), 0);

    // Underrun on an empty FIFO
    enable = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("pre_underrun", int'(underrun), 0);
    step();
    check("underrun_set", int'(underrun), 1);
    enable = 1'b0;
`ifdef WAVUNO_UNDERRUN_MUTE_EN
    expect_duty("underrun_mute", 128, 128);
`else
    expect_duty("underrun_hold", 170, 187);
`endif
    clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
    check("underrun_cleared", int'(underrun), 0);

    // Push into an empty FIFO on the tick, with clr_flags in the same cycle
    enable = 1'b1;
    repeat (9) @(posedge clk);
    #1;
    wr_left = 1'b1;
    wr_data = 8'h60;
    step();
    wr_left   = 1'b0;
    wr_right  = 1'b1;
    wr_data   = 8'h61;
    clr_flags = 1'b1;
    step();
    wr_right  = 1'b0;
    clr_flags = 1'b0;
    enable    = 1'b0;
    check("tickpush_underrun", int'(underrun), 1);
    check("tickpush_count", int'(fifo_count), 1);

    // wr_left and wr_right together use the old pending left
    wr_left = 1'b1;
    wr_data = 8'h33;
    step();
    wr_right = 1'b1;
    wr_data  = 8'h44;
    step();
    wr_left = 1'b0;
    wr_data = 8'h55;
    step();
    wr_right = 1'b0;
    check("both_count", int'(fifo_count), 3);
    pop_one();
    expect_duty("q0", 96, 97);
    pop_one();
    expect_duty("q1", 51, 68);
    pop_one();
    expect_duty("q2", 68, 85);

    // Reset mid-play
    for (int i = 0; i < 5; i++) push(8'(8'h11 + i), 8'(8'h21 + i));
    check("mid_count", int'(fifo_count), 5);
    check("mid_underrun", int'(underrun), 1);
    enable = 1'b1;
    repeat (4) step();
    rst = 1'b1;
    #1;
    check("arst_count", int'(fifo_count), 0);
    check("arst_empty", int'(fifo_empty), 1);
    check("arst_underrun", int'(underrun), 0);
    check("arst_overflow", int'(overflow), 0);
    check("arst_out_l", int'(audio_out_left), 0);
    check("arst_out_r", int'(audio_out_right), 0);
    enable = 1'b0;
    step();
    rst = 1'b0;
    expect_duty("post_rst", 128, 128);
    check("post_rst_count", int'(fifo_count), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/wavuno_sample_player.md
# wavuno_sample_player

Streaming stereo PCM playback stage for the WAV add-on. Sits downstream of the CPU I/O port decoder and drives the board audio pins. The CPU writes 8-bit unsigned left/right samples into a small FIFO. A programmable sample-rate divider pops one stereo pair per sample period and feeds two first-order sigma-delta modulators. Their 1-bit outputs go to `audio_out_left` and `audio_out_right`.

## Interface
Parameters:
- `FIFO_AW`, 4: FIFO address width; depth is 2**FIFO_AW stereo pairs (16).
- `DIV_W`, 12: width of the sample-period divider.

Ports:
- `clk` in 1: system clock (28 MHz `sysclk` domain).
- `rst` in 1: asynchronous, active-high reset.
- `enable` in 1: playback enable; level-sensitive.
- `rate_div` in DIV_W: sample period minus 1, in `clk` cycles (634 gives 44.1 kHz at 28 MHz).
- `wr_left` in 1: one-cycle strobe; latches `wr_data` as the pending left sample.
- `wr_right` in 1: one-cycle strobe; pushes {pending left, `wr_data`} into the FIFO.
- `wr_data` in 8: unsigned sample byte, midscale 0x80.
- `clr_flags` in 1: one-cycle strobe; clears `underrun` and `overflow`.
- `fifo_count` out FIFO_AW+1: number of pairs stored.
- `fifo_full` out 1: asserted when count = depth.
- `fifo_empty` out 1: asserted when count = 0.
- `underrun` out 1: sticky; set when a tick finds the FIFO empty.
- `overflow` out 1: sticky; set when `wr_right` arrives while the FIFO is full.
- `audio_out_left` out 1: sigma-delta bitstream, left channel.
- `audio_out_right` out 1: sigma-delta bitstream, right channel.

## Operation
- **Reset values:**
  - FIFO pointers and count 0; `fifo_empty`=1, `fifo_full`=0.
  - `underrun`=0, `overflow`=0.
  - Pending left latch, current left and current right = 0x80.
  - Divider counter 0; modulator accumulators 0; both audio outputs 0.
- **States:** IDLE (`enable`=0) and PLAY (`enable`=1).
- **IDLE:**
  - Divider held at `rate_div`.
  - No pops.
  - Modulators keep running on the current samples.
  - Pushes are still accepted, which allows prefill.
- **IDLE to PLAY:** the divider counts down from `rate_div`. A tick occurs in the cycle the counter equals 0; the counter then reloads `rate_div`. The first tick is therefore rate_div+1 cycles after `enable` rises.
- **PLAY to IDLE:** takes effect immediately. A tick coinciding with the deasserting cycle is suppressed.
- **Tick with FIFO non-empty:** pop the head pair into the current left/right registers.
- **Tick with FIFO empty:** set `underrun`; the current samples follow the configuration section.
- **Push (`wr_right`):**
  - Writes {pending left, `wr_data`}.
  - If full and no pop occurs in the same cycle: the write is dropped and `overflow` is set.
  - Simultaneous push and pop while full: both occur; count unchanged; no overflow.
- **Push while empty coinciding with a tick:** the push succeeds, there is no bypass, and `underrun` is set.
- **`wr_left` and `wr_right` in the same cycle:** the pushed pair uses the old pending left; the latch then takes `wr_data`.
- **`clr_flags` coinciding with a new set event:** the set wins.
- **Modulator (per channel):** 9-bit accumulator, acc <= {1'b0, acc[7:0]} + sample; output = registered acc[8]. Output duty cycle equals sample/256.
- **`rate_div` changes** take effect at the next reload.

## Timing
- Push to `fifo_count` / flag update: 1 cycle.
- Tick to current-sample update: registered, visible the cycle after the tick.
- Current sample to output bit: 1 cycle (accumulator), then output register: 2 cycles total.
- Flags are registered and update 1 cycle after their causing event.
- An asynchronous `rst` mid-playback returns everything to reset values immediately; FIFO contents are discarded.

## Configuration
- `WAVUNO_UNDERRUN_MUTE_EN` defined: an underrun tick loads 0x80 into both current samples (silence).
- Macro undefined: an underrun tick leaves the current samples unchanged (hold last pair).
- `underrun` flag behaviour is identical in both builds.

## Structure
- Package `wavuno_pkg`: sample width 8, midscale constant 0x80, default FIFO_AW, and the IDLE/PLAY state encoding.
- Natural sub-module: `wavuno_sd_dac` (one-channel first-order sigma-delta), instantiated twice.
- FIFO is inferred register or distributed RAM inside the top block.

## Test plan
- **Reset defaults:** reset, then hold `enable`=0 for 100 cycles -> `fifo_empty`=1, `fifo_count`=0, both outputs produce 50% duty (0x80) over 256 cycles.
- **Prefill and play:** push pairs (0x10,0xF0), (0x20,0xE0); set `rate_div`=9 and `enable`=1 -> first pop at cycle 10; the left output averages 16/256 high over the next 256 cycles; count decrements to 0 after two ticks.
- **Overflow:** push 17 pairs with `enable`=0 -> `fifo_full`=1, count 16, `overflow`=1, and the 17th pair is absent from the popped sequence; `clr_flags` -> `overflow`=0.
- **Full with simultaneous pop:** push on the tick cycle while full -> count stays 16, `overflow`=0.
- **Underrun:** play with an empty FIFO -> `underrun`=1 at the first tick; the current sample is 0x80 with the macro and the last pair without it.
- **Reset mid-play:** assert `rst` with 5 pairs queued -> count 0, outputs 0, flags 0 immediately.
